seq_shift_unit: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the 24-bit datapath. It is the successor of the single-cycle SLL block and adds SRL, SRA, ROL and ROR modes.
- The shift amount is the sum of a register operand and an immediate.
- The unit shifts by up to STEP bits per cycle, trading latency for area.
- Valid/ready handshakes sit on both sides, so the unit can stall the pipeline or sit behind an ALU mux.

---
 rtl/seq_shift_unit.sv | 196 +++++++++++++++++++
 tb/tb_seq_shift_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit (SLL/SRL/SRA/ROL/ROR) with valid/ready on both sides.
// Optional carry_out port when SEQ_SHIFT_CARRY_EN is defined.
module seq_shift_unit #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AMT_W = 24,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [AMT_W-1:0] b_in,
    input  logic [AMT_W-1:0] amt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef SEQ_SHIFT_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam int unsigned RAW_W = AMT_W + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   rem_q, rem_n;
    logic [2:0]         mode_q, mode_n;
    logic               sign_q, sign_n;
    logic [WIDTH-1:0]   result_n;
    logic               out_valid_n;
    logic               in_ready_n;

    logic [RAW_W-1:0]   raw_c;
    logic [CNT_W-1:0]   sat_c;
    logic [CNT_W-1:0]   rot_c;
    logic [CNT_W-1:0]   eff_c;
    logic [CNT_W-1:0]   k_c;
    logic [WIDTH-1:0]   fill_c;
    logic [WIDTH-1:0]   shift_c;

    // Raw amount keeps the carry of the add so large operands never wrap to a small shift
    assign raw_c = RAW_W'(b_in) + RAW_W'(amt_in);
    assign sat_c = (raw_c >= RAW_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(raw_c);
    assign rot_c = CNT_W'(raw_c % RAW_W'(WIDTH));

    always_comb begin
        eff_c = '0;
        case (mode)
            MODE_SLL, MODE_SRL, MODE_SRA: eff_c = sat_c;
            MODE_ROL, MODE_ROR:           eff_c = rot_c;
            default:                      eff_c = '0;
        endcase
    end

    // Per-cycle step: at most STEP bits, never more than what is left
    assign k_c    = (rem_q > CNT_W'(STEP)) ? CNT_W'(STEP) : rem_q;
    assign fill_c = sign_q ? ~({WIDTH{1'b1}} >> k_c) : '0;

    always_comb begin
        shift_c = result;
        case (mode_q)
            MODE_SLL: shift_c = result << k_c;
            MODE_SRL: shift_c = result >> k_c;
            MODE_SRA: shift_c = (result >> k_c) | fill_c;
            MODE_ROL: shift_c = (result << k_c) | (result >> (CNT_W'(WIDTH) - k_c));
            MODE_ROR: shift_c = (result >> k_c) | (result << (CNT_W'(WIDTH) - k_c));
            default:  shift_c = result;
        endcase
    end

`ifdef SEQ_SHIFT_CARRY_EN
    logic               over_q, over_n;
    logic               carry_n;
    logic               step_carry_c;
    logic [CNT_W-1:0]   lo_idx_c;
    logic [CNT_W-1:0]   hi_idx_c;

    // Last bit leaving the word: bit WIDTH-k for left moves, bit k-1 for right moves
    assign lo_idx_c = k_c - CNT_W'(1);
    assign hi_idx_c = CNT_W'(WIDTH) - k_c;

    always_comb begin
        step_carry_c = 1'b0;
        case (mode_q)
            MODE_SLL, MODE_ROL:           step_carry_c = result[hi_idx_c];
            MODE_SRL, MODE_SRA, MODE_ROR: step_carry_c = result[lo_idx_c];
            default:                      step_carry_c = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem_q     <= '0;
            mode_q    <= '0;
            sign_q    <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SEQ_SHIFT_CARRY_EN
            over_q    <= 1'b0;
            carry_out <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            rem_q     <= rem_n;
            mode_q    <= mode_n;
            sign_q    <= sign_n;
            result    <= result_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
`ifdef SEQ_SHIFT_CARRY_EN
            over_q    <= over_n;
            carry_out <= carry_n;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        rem_n       = rem_q;
        mode_n      = mode_q;
        sign_n      = sign_q;
        result_n    = result;
        out_valid_n = out_valid;
        in_ready_n  = in_ready;
`ifdef SEQ_SHIFT_CARRY_EN
        over_n      = over_q;
        carry_n     = carry_out;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    result_n   = a_in;
                    mode_n     = mode;
                    sign_n     = a_in[WIDTH-1];
                    rem_n      = eff_c;
                    in_ready_n = 1'b0;
                    state_n    = (eff_c == '0) ? DONE : SHIFT;
`ifdef SEQ_SHIFT_CARRY_EN
                    over_n     = (raw_c > RAW_W'(WIDTH)) && (mode <= MODE_SRA);
                    carry_n    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                result_n = shift_c;
                rem_n    = rem_q - k_c;
                if (rem_q == k_c) begin
                    state_n = DONE;
                end
`ifdef SEQ_SHIFT_CARRY_EN
                // Shifting past the word pushes out only zeros, or sign copies for SRA
                if ((rem_q == k_c) && over_q) begin
                    carry_n = (mode_q == MODE_SRA) ? sign_q : 1'b0;
                end else begin
                    carry_n = step_carry_c;
                end
`endif
            end
            DONE: begin
                // One settle cycle raises out_valid; out_ready only counts once it is up
                if (!out_valid) begin
                    out_valid_n = 1'b1;
                end else if (out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                in_ready_n  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: vector table plus backpressure and mid-op reset sequences.
module tb_seq_shift_unit;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned AMT_W = 24;
    localparam int unsigned STEP  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       mode;
    logic [WIDTH-1:0] a_in;
    logic [AMT_W-1:0] b_in;
    logic [AMT_W-1:0] amt_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef SEQ_SHIFT_CARRY_EN
    logic             carry_out;
`endif

    seq_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a_in      (a_in),
        .b_in      (b_in),
        .amt_in    (amt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef SEQ_SHIFT_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [2:0]       mode;
        logic [WIDTH-1:0] a;
        logic [AMT_W-1:0] b;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] exp_res;
        int               exp_lat;
        logic             exp_c;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(input string name, input logic [2:0] m, input logic [WIDTH-1:0] a,
                                input logic [AMT_W-1:0] b, input logic [AMT_W-1:0] amt,
                                input logic [WIDTH-1:0] r, input int lat, input logic c);
        vec_t v;
        v.name = name; v.mode = m; v.a = a; v.b = b; v.amt = amt;
        v.exp_res = r; v.exp_lat = lat; v.exp_c = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic issue(input logic [2:0] m, input logic [WIDTH-1:0] a,
                         input logic [AMT_W-1:0] b, input logic [AMT_W-1:0] amt);
        @(negedge clk);
        mode = m; a_in = a; b_in = b; amt_in = amt; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge until out_valid is seen (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic handshake(input string name);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        issue(v.mode, v.a, v.b, v.amt);
        wait_valid(lat);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, "_result"}, 32'(result), 32'(v.exp_res));
`ifdef SEQ_SHIFT_CARRY_EN
        chk({v.name, "_carry"}, 32'(carry_out), 32'(v.exp_c));
`endif
        handshake(v.name);
    endtask

    initial begin
        int lat;
        logic seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = '0; a_in = '0; b_in = '0; amt_in = '0;

        vecs.push_back(mk("sll5",     3'b000, 24'h000001, 24'd2,  24'd3, 24'h000020, 3, 1'b0));
        vecs.push_back(mk("sra4",     3'b010, 24'h800000, 24'd0,  24'd4, 24'hF80000, 2, 1'b0));
        vecs.push_back(mk("srl4",     3'b001, 24'h800000, 24'd0,  24'd4, 24'h080000, 2, 1'b0));
        vecs.push_back(mk("rol25",    3'b011, 24'h800001, 24'd20, 24'd5, 24'h000003, 2, 1'b1));
        vecs.push_back(mk("ror48",    3'b100, 24'h000001, 24'd40, 24'd8, 24'h000001, 1, 1'b0));
        vecs.push_back(mk("srl30",    3'b001, 24'hFFFFFF, 24'd30, 24'd0, 24'h000000, 7, 1'b0));
        vecs.push_back(mk("nop101",   3'b101, 24'h123456, 24'd5,  24'd1, 24'h123456, 1, 1'b0));
        vecs.push_back(mk("sra100",   3'b010, 24'hA5A5A5, 24'd100, 24'd0, 24'hFFFFFF, 7, 1'b1));
        vecs.push_back(mk("sll24",    3'b000, 24'hFFFFFF, 24'd24, 24'd0, 24'h000000, 7, 1'b1));
        vecs.push_back(mk("srl24",    3'b001, 24'h800000, 24'd24, 24'd0, 24'h000000, 7, 1'b1));
        vecs.push_back(mk("ror1",     3'b100, 24'h000001, 24'd1,  24'd0, 24'h800000, 2, 1'b1));
        vecs.push_back(mk("rol8",     3'b011, 24'h123456, 24'd3,  24'd5, 24'h345612, 3, 1'b0));
        vecs.push_back(mk("sra_cy",   3'b010, 24'h7FFFFF, 24'hFFFFFF, 24'd1, 24'h000000, 7, 1'b0));
        vecs.push_back(mk("sll_max",  3'b000, 24'h000001, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 7, 1'b0));
        vecs.push_back(mk("rol_2p24", 3'b011, 24'h000001, 24'hFFFFFF, 24'd1, 24'h010000, 5, 1'b0));
        vecs.push_back(mk("nop111",   3'b111, 24'hFEDCBA, 24'd9,  24'd9, 24'hFEDCBA, 1, 1'b0));
        vecs.push_back(mk("ror4",     3'b100, 24'h123456, 24'd4,  24'd0, 24'h612345, 2, 1'b0));
        vecs.push_back(mk("sll23",    3'b000, 24'h000001, 24'd20, 24'd3, 24'h800000, 7, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SEQ_SHIFT_CARRY_EN
        chk("rst_carry", 32'(carry_out), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Backpressure: result held, second request waits until the unit is idle again
        issue(3'b000, 24'h000001, 24'd1, 24'd0);
        wait_valid(lat);
        chk("bp_first_latency", 32'(lat), 32'd2);
        @(negedge clk);
        mode = 3'b001; a_in = 24'hF00000; b_in = 24'd4; amt_in = 24'd0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", 32'(result), 32'h000002);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        handshake("bp");
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_second_taken", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("bp_second_latency", 32'(lat), 32'd2);
        chk("bp_second_result", 32'(result), 32'h0F0000);
        handshake("bp2");

        // Reset pulse in the middle of an SLL by 20 drops the request
        issue(3'b000, 24'h000001, 24'd20, 24'd0);
        @(posedge clk);
        #1;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result_after", 32'(result), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        run_vec(mk("post_rst", 3'b100, 24'h000001, 24'd0, 24'd1, 24'h800000, 2, 1'b1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
